mem_arbiter: RTL and testbench

- Two-requester arbiter sharing the single-port 256x8 `memory` block between instruction fetch (port 0) and data load/store (port 1).
- Grants at most one access per cycle and drives the memory enables.
- Tracks the one-cycle registered read latency and routes `mem_out` back to the requester that issued the read.
- Starvation guard under fixed priority; round-robin available by macro.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 46 ++++
 rtl/mem_arb_starve_ctr.sv | 35 +++
 rtl/mem_arbiter.sv | 117 +++++++++++
 tb/tb_mem_arbiter.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the two-port memory arbiter.
// Widths are fixed by the 256x8 single-port memory the arbiter fronts.
package mem_arb_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;

    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_DATA  = 1'b1
    } req_id_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-side signals of the arbiter.
// The slave modport is the arbiter; master is the requesters plus memory.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              req0_valid;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;

    logic              req1_valid;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_in;
    logic              memory_w_en;
    logic              memory_r_en;
    logic [DATA_W-1:0] mem_out;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_addr, mem_in, memory_w_en, memory_r_en,
        input  mem_out
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_addr, mem_in, memory_w_en, memory_r_en,
        output mem_out
    );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating 4-bit count of consecutive denied cycles for one requester.
module mem_arb_starve_ctr #(
    parameter int unsigned Limit = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_limit
);

    localparam logic [3:0] LimitW = 4'(Limit);

    logic [3:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != LimitW)) begin
            cnt_d = cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign at_limit = (cnt_q == LimitW);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch (port 0) and data (port 1) onto one single-port memory.
// MEM_ARBITER_RR_EN selects round-robin; default is fixed priority with starvation guard.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);

    mem_req_t          req0, req1, gnt_req;
    logic              gnt_valid;
    req_id_t           gnt_id;
    logic              prefer0;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              pend_q;
    req_id_t           owner_q;
    logic              ready0, ready1, rsp0_v, rsp1_v;

    assign req0 = '{we: bus.req0_we, addr: bus.req0_addr, wdata: bus.req0_wdata};
    assign req1 = '{we: bus.req1_we, addr: bus.req1_addr, wdata: bus.req1_wdata};

`ifdef MEM_ARBITER_RR_EN
    req_id_t ptr_q;

    assign prefer0 = (ptr_q == REQ_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= REQ_FETCH;
        end else if (gnt_valid) begin
            ptr_q <= (gnt_id == REQ_FETCH) ? REQ_DATA : REQ_FETCH;
        end
    end
`else
    logic lim0, lim1;

    mem_arb_starve_ctr #(.Limit(STARVE_LIMIT)) u_starve0 (
        .clk      (clk),
        .rst      (rst),
        .inc      (bus.req0_valid & ~ready0),
        .clr      (~bus.req0_valid | ready0),
        .at_limit (lim0)
    );

    mem_arb_starve_ctr #(.Limit(STARVE_LIMIT)) u_starve1 (
        .clk      (clk),
        .rst      (rst),
        .inc      (bus.req1_valid & ~ready1),
        .clr      (~bus.req1_valid | ready1),
        .at_limit (lim1)
    );

    // A starved fetch port wins; this also covers both counters at limit.
    // A starved data port already wins under the default priority.
    logic unused_lim1;
    assign unused_lim1 = lim1;
    assign prefer0     = lim0;
`endif

    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = REQ_FETCH;
        if (!rst) begin
            if (bus.req0_valid && bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = prefer0 ? REQ_FETCH : REQ_DATA;
            end else if (bus.req0_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = REQ_FETCH;
            end else if (bus.req1_valid) begin
                gnt_valid = 1'b1;
                gnt_id    = REQ_DATA;
            end
        end
    end

    assign gnt_req = (gnt_id == REQ_DATA) ? req1 : req0;
    assign ready0  = gnt_valid & (gnt_id == REQ_FETCH);
    assign ready1  = gnt_valid & (gnt_id == REQ_DATA);

    assign bus.req0_ready  = ready0;
    assign bus.req1_ready  = ready1;
    assign bus.memory_r_en = gnt_valid & ~gnt_req.we;
    assign bus.memory_w_en = gnt_valid & gnt_req.we;
    assign bus.mem_addr    = gnt_valid ? gnt_req.addr  : addr_q;
    assign bus.mem_in      = gnt_valid ? gnt_req.wdata : wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            pend_q  <= 1'b0;
            owner_q <= REQ_FETCH;
        end else begin
            pend_q  <= gnt_valid & ~gnt_req.we;
            owner_q <= gnt_id;
            if (gnt_valid) begin
                addr_q  <= gnt_req.addr;
                wdata_q <= gnt_req.wdata;
            end
        end
    end

    // Gating with rst drops a read whose data would land during reset.
    assign rsp0_v = pend_q & ~rst & (owner_q == REQ_FETCH);
    assign rsp1_v = pend_q & ~rst & (owner_q == REQ_DATA);

    assign bus.rsp0_valid = rsp0_v;
    assign bus.rsp1_valid = rsp1_v;
    assign bus.rsp0_rdata = rsp0_v ? bus.mem_out : '0;
    assign bus.rsp1_rdata = rsp1_v ? bus.mem_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 256x8 registered-read memory.
// Contention expectations follow MEM_ARBITER_RR_EN when it is defined.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    mem_arbiter_if bus ();

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] mem [256];
    logic [7:0] mem_out_q;

    always @(posedge clk) begin
        if (bus.memory_w_en) mem[bus.mem_addr] <= bus.mem_in;
        if (bus.memory_r_en) mem_out_q <= mem[bus.mem_addr];
    end
    assign bus.mem_out = mem_out_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
        bus.req0_valid = v;
        bus.req0_we    = we;
        bus.req0_addr  = a;
        bus.req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [7:0] a, input logic [7:0] d);
        bus.req1_valid = v;
        bus.req1_we    = we;
        bus.req1_addr  = a;
        bus.req1_wdata = d;
    endtask

    int exp_g [11];
    int prev_g;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        mem[8'h00] <= 8'h55;
        mem[8'h01] <= 8'h05;
        mem[8'h02] <= 8'hB5;
        mem[8'h04] <= 8'hCA;
        mem[8'hFF] <= 8'h3C;
        mem_out_q  <= 8'h00;

        // Reset held with both requesters active.
        rst = 1'b1;
        drive0(1'b1, 1'b0, 8'h11, 8'h00);
        drive1(1'b1, 1'b0, 8'h22, 8'h00);
        repeat (2) begin
            @(negedge clk); #1;
            check("rst_ready0", 32'(bus.req0_ready), 32'd0);
            check("rst_ready1", 32'(bus.req1_ready), 32'd0);
            check("rst_r_en", 32'(bus.memory_r_en), 32'd0);
            check("rst_w_en", 32'(bus.memory_w_en), 32'd0);
            check("rst_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
            check("rst_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
            check("rst_rsp0_rdata", 32'(bus.rsp0_rdata), 32'd0);
            check("rst_rsp1_rdata", 32'(bus.rsp1_rdata), 32'd0);
        end
        @(negedge clk);
        rst = 1'b0;
        drive0(1'b0, 1'b0, 8'h00, 8'h00);
        drive1(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("idle_mem_addr", 32'(bus.mem_addr), 32'h00);
        check("idle_mem_in", 32'(bus.mem_in), 32'h00);

        // Single fetch read of 0x00.
        @(negedge clk);
        drive0(1'b1, 1'b0, 8'h00, 8'h00);
        #1;
        check("rd_ready0", 32'(bus.req0_ready), 32'd1);
        check("rd_r_en", 32'(bus.memory_r_en), 32'd1);
        check("rd_w_en", 32'(bus.memory_w_en), 32'd0);
        @(negedge clk);
        drive0(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("rd_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        check("rd_rsp0_rdata", 32'(bus.rsp0_rdata), 32'h55);
        check("rd_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        check("rd_r_en_after", 32'(bus.memory_r_en), 32'd0);

        // Contention: both read every cycle; last entry is an idle cycle (2 = no grant).
`ifdef MEM_ARBITER_RR_EN
        exp_g = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0, 2};
`else
        exp_g = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 2};
`endif
        prev_g = 2;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive0(exp_g[i] != 2, 1'b0, 8'h01, 8'h00);
            drive1(exp_g[i] != 2, 1'b0, 8'h02, 8'h00);
            #1;
            check("cont_ready0", 32'(bus.req0_ready), 32'(exp_g[i] == 0));
            check("cont_ready1", 32'(bus.req1_ready), 32'(exp_g[i] == 1));
            check("cont_rsp0_valid", 32'(bus.rsp0_valid), 32'(prev_g == 0));
            check("cont_rsp1_valid", 32'(bus.rsp1_valid), 32'(prev_g == 1));
            check("cont_rsp0_rdata", 32'(bus.rsp0_rdata), (prev_g == 0) ? 32'h05 : 32'h00);
            check("cont_rsp1_rdata", 32'(bus.rsp1_rdata), (prev_g == 1) ? 32'hB5 : 32'h00);
            prev_g = exp_g[i];
        end

        // Write then read the same address on the data port.
        @(negedge clk);
        drive1(1'b1, 1'b1, 8'h10, 8'hA5);
        #1;
        check("wr_ready1", 32'(bus.req1_ready), 32'd1);
        check("wr_w_en", 32'(bus.memory_w_en), 32'd1);
        check("wr_r_en", 32'(bus.memory_r_en), 32'd0);
        check("wr_mem_addr", 32'(bus.mem_addr), 32'h10);
        check("wr_mem_in", 32'(bus.mem_in), 32'hA5);
        @(negedge clk);
        drive1(1'b1, 1'b0, 8'h10, 8'h00);
        #1;
        check("raw_r_en", 32'(bus.memory_r_en), 32'd1);
        check("raw_no_wr_rsp", 32'(bus.rsp1_valid), 32'd0);
        @(negedge clk);
        drive1(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("raw_rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
        check("raw_rsp1_rdata", 32'(bus.rsp1_rdata), 32'hA5);
        check("hold_mem_addr", 32'(bus.mem_addr), 32'h10);
        check("hold_w_en", 32'(bus.memory_w_en), 32'd0);

        // Top address is used as-is.
        @(negedge clk);
        drive1(1'b1, 1'b0, 8'hFF, 8'h00);
        #1;
        check("wrap_mem_addr", 32'(bus.mem_addr), 32'hFF);
        @(negedge clk);
        drive1(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("wrap_rsp1_rdata", 32'(bus.rsp1_rdata), 32'h3C);

        // Reset arrives the cycle after a read grant.
        @(negedge clk);
        drive0(1'b1, 1'b0, 8'h04, 8'h00);
        #1;
        check("rstmid_r_en", 32'(bus.memory_r_en), 32'd1);
        @(negedge clk);
        drive0(1'b0, 1'b0, 8'h00, 8'h00);
        rst = 1'b1;
        #1;
        check("rstmid_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        check("rstmid_rsp0_rdata", 32'(bus.rsp0_rdata), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rstpost_rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
        check("rstpost_rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
        check("rstpost_mem_addr", 32'(bus.mem_addr), 32'h00);
        @(negedge clk);
        drive0(1'b1, 1'b0, 8'h04, 8'h00);
        #1;
        check("rerd_ready0", 32'(bus.req0_ready), 32'd1);
        @(negedge clk);
        drive0(1'b0, 1'b0, 8'h00, 8'h00);
        #1;
        check("rerd_rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
        check("rerd_rsp0_rdata", 32'(bus.rsp0_rdata), 32'hCA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
